// File: rtl/load_store_unit_if.sv
// ============================================================================
// load_store_unit_if : request/response and RAM bus bundle for load_store_unit
// Rev 1.0
// ============================================================================
`default_nettype none

interface load_store_unit_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              resp_valid;
  logic              resp_err;
  logic [DATA_W-1:0] resp_rdata;

  logic              ram_ce;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  // Core plus RAM side: drives requests and read data, observes everything else.
  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output ram_rdata,
    input  req_ready, resp_valid, resp_err, resp_rdata,
    input  ram_ce, ram_we, ram_addr, ram_wdata
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  ram_rdata,
    output req_ready, resp_valid, resp_err, resp_rdata,
    output ram_ce, ram_we, ram_addr, ram_wdata
  );
endinterface

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// load_store_unit : byte/half/word load-store front-end onto a word-wide RAM
// Rev 1.0
// ============================================================================
`default_nettype none

module load_store_unit #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  load_store_unit_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } state_t;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  state_t            state;
  logic              op_we;
  logic [1:0]        op_size;
  logic              op_signed;
  logic [1:0]        op_lane;
  logic [15:0]       op_wdata;
  logic [DATA_W-1:0] merge_buf;

  logic              resp_valid_q;
  logic              resp_err_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic              ram_ce_q;
  logic              ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;

  logic              accept;
  logic              req_bad;
  logic [ADDR_W-1:0] aligned_addr;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [DATA_W-1:0] load_word;
  logic [DATA_W-1:0] wr_word;

  assign accept       = bus.req_valid & bus.req_ready;
  assign aligned_addr = {bus.req_addr[ADDR_W-1:2], 2'b00};

  always_comb begin
    case (bus.req_size)
      SIZE_B:  req_bad = 1'b0;
      SIZE_H:  req_bad = bus.req_addr[0];
      SIZE_W:  req_bad = |bus.req_addr[1:0];
      default: req_bad = 1'b1;
    endcase
  end

  // Lane extraction works on the live RAM data seen during CAP.
  always_comb begin
    case (op_lane)
      2'd0:    rd_byte = bus.ram_rdata[7:0];
      2'd1:    rd_byte = bus.ram_rdata[15:8];
      2'd2:    rd_byte = bus.ram_rdata[23:16];
      default: rd_byte = bus.ram_rdata[31:24];
    endcase
    rd_half = op_lane[1] ? bus.ram_rdata[31:16] : bus.ram_rdata[15:0];
    case (op_size)
      SIZE_B:  load_word = {{24{op_signed & rd_byte[7]}}, rd_byte};
      SIZE_H:  load_word = {{16{op_signed & rd_half[15]}}, rd_half};
      default: load_word = bus.ram_rdata;
    endcase
  end

  // Word stores preload merge_buf with the full store data, so no lane is replaced.
  always_comb begin
    wr_word = merge_buf;
    case (op_size)
      SIZE_B: begin
        case (op_lane)
          2'd0:    wr_word[7:0]   = op_wdata[7:0];
          2'd1:    wr_word[15:8]  = op_wdata[7:0];
          2'd2:    wr_word[23:16] = op_wdata[7:0];
          default: wr_word[31:24] = op_wdata[7:0];
        endcase
      end
      SIZE_H: begin
        if (op_lane[1]) wr_word[31:16] = op_wdata;
        else            wr_word[15:0]  = op_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      op_we        <= 1'b0;
      op_size      <= 2'b00;
      op_signed    <= 1'b0;
      op_lane      <= 2'b00;
      op_wdata     <= 16'h0;
      merge_buf    <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      ram_ce_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_we     <= bus.req_we;
            op_size   <= bus.req_size;
            op_signed <= bus.req_signed;
            op_lane   <= bus.req_addr[1:0];
            op_wdata  <= bus.req_wdata[15:0];
            if (req_bad) begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
              state        <= RESP;
            end else begin
              ram_ce_q   <= 1'b1;
              ram_addr_q <= aligned_addr;
              if (bus.req_we && bus.req_size == SIZE_W) begin
                merge_buf <= bus.req_wdata;
                ram_we_q  <= 1'b1;
                state     <= WR;
              end else begin
                state <= RD;
              end
            end
          end
        end
        RD: state <= CAP;
        CAP: begin
          merge_buf <= bus.ram_rdata;
          if (op_we) begin
            ram_we_q <= 1'b1;
            state    <= WR;
          end else begin
            resp_rdata_q <= load_word;
            resp_valid_q <= 1'b1;
            ram_ce_q     <= 1'b0;
            ram_addr_q   <= '0;
            state        <= RESP;
          end
        end
        WR: begin
          ram_ce_q     <= 1'b0;
          ram_we_q     <= 1'b0;
          ram_addr_q   <= '0;
          resp_rdata_q <= '0;
          resp_valid_q <= 1'b1;
          state        <= RESP;
        end
        RESP: begin
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state == IDLE) & ~rst;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.ram_ce     = ram_ce_q;
  // A write cycle that meets a reset edge must never reach the RAM.
  assign bus.ram_we     = ram_we_q & ~rst;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_wdata  = (state == WR) ? wr_word : '0;

endmodule

`default_nettype wire
